pe_tx_arbiter: RTL and testbench

PE_TX_ARBITER -- requirements
Module: pe_tx_arbiter

---
 rtl/pe_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_pe_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pe_tx_arbiter
//
// Shares the single PE-to-NI injection port between two packet sources: the
// activation-function output (AF) and the control/status reply path (CTL).
// A one-entry registered output stage sits in front of the NI. It can be
// unloaded and reloaded in the same cycle, so the sustained throughput is one
// packet per cycle. When both sources request together, the source that was
// not granted most recently wins. This gives strict alternation under
// contention.
//
// Ports
//   clk             sole clock, rising edge
//   rst             asynchronous reset, active low
//   AF_ARB_valid    AF has a packet
//   AF_ARB_packet   AF packet {type, seq, dest, source, payload}
//   AF_ARB_ready    AF packet accepted this cycle
//   CTL_ARB_valid   CTL has a packet
//   CTL_ARB_packet  CTL packet
//   CTL_ARB_ready   CTL packet accepted this cycle
//   ARB_NI_valid    output stage holds a packet
//   ARB_NI_packet   packet presented to the NI
//   ARB_NI_ready    NI takes the packet this cycle
//   ARB_pktCount    packets delivered to the NI, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module pe_tx_arbiter #(
   parameter int NETWORK_SIZE = 256,
   // The seq field is $clog2(sqrt(N)*2) bits wide. That equals
   // 1 + ceil(log2(N)/2), which keeps this an integer-only expression.
   localparam int PACKET_SIZE = 32 + 2*$clog2(NETWORK_SIZE)
                                + (1 + ($clog2(NETWORK_SIZE) + 1) / 2) + 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   AF_ARB_valid,
   input  logic [PACKET_SIZE-1:0] AF_ARB_packet,
   output logic                   AF_ARB_ready,
   input  logic                   CTL_ARB_valid,
   input  logic [PACKET_SIZE-1:0] CTL_ARB_packet,
   output logic                   CTL_ARB_ready,
   output logic                   ARB_NI_valid,
   output logic [PACKET_SIZE-1:0] ARB_NI_packet,
   input  logic                   ARB_NI_ready,
   output logic [15:0]            ARB_pktCount
);

   // output stage occupancy
   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   // lastGrant encoding
   localparam logic GNT_AF  = 1'b0;
   localparam logic GNT_CTL = 1'b1;

   logic                   state;
   logic                   last_grant;
   logic [PACKET_SIZE-1:0] out_pkt;
   logic [15:0]            pkt_count;

   logic load_ok;
   logic sel_ctl;
   logic load;
   logic deliver;

   // The stage can take a new packet when it is empty, or when the NI drains
   // it on this same edge.
   assign load_ok = (state == EMPTY) | ARB_NI_ready;
   assign deliver = (state == FULL) & ARB_NI_ready;

   // Selection looks only at the valids and lastGrant, never at the packet
   // buses, so ready carries no combinational path from the data.
   always_comb begin
      sel_ctl = CTL_ARB_valid;
      if (AF_ARB_valid && CTL_ARB_valid)
         sel_ctl = (last_grant == GNT_AF);
   end

   // Gating with rst holds both readies low during reset. The first
   // acceptance can then happen on the first edge after release.
   assign AF_ARB_ready  = rst & load_ok & AF_ARB_valid  & ~sel_ctl;
   assign CTL_ARB_ready = rst & load_ok & CTL_ARB_valid &  sel_ctl;
   assign load          = AF_ARB_ready | CTL_ARB_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= EMPTY;
      else if (load)
         state <= FULL;
      else if (deliver)
         state <= EMPTY;
   end

   // A load during delivery overwrites the departing packet directly.
   // This avoids a bubble cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         out_pkt <= '0;
      else if (load)
         out_pkt <= sel_ctl ? CTL_ARB_packet : AF_ARB_packet;
   end

   // Reset value is CTL, so AF wins the first tie after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= GNT_CTL;
      else if (load)
         last_grant <= sel_ctl ? GNT_CTL : GNT_AF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pkt_count <= '0;
      else if (deliver && (pkt_count != 16'hFFFF))
         pkt_count <= pkt_count + 16'd1;
   end

   assign ARB_NI_valid  = (state == FULL);
   assign ARB_NI_packet = out_pkt;
   assign ARB_pktCount  = pkt_count;

endmodule

// File: tb/tb_pe_tx_arbiter.sv
module tb_pe_tx_arbiter;

   localparam int PW = 56;

   logic          clk;
   logic          rst;
   logic          AF_ARB_valid;
   logic [PW-1:0] AF_ARB_packet;
   logic          AF_ARB_ready;
   logic          CTL_ARB_valid;
   logic [PW-1:0] CTL_ARB_packet;
   logic          CTL_ARB_ready;
   logic          ARB_NI_valid;
   logic [PW-1:0] ARB_NI_packet;
   logic          ARB_NI_ready;
   logic [15:0]   ARB_pktCount;

   pe_tx_arbiter #(.NETWORK_SIZE(256)) dut (
      .clk           (clk),
      .rst           (rst),
      .AF_ARB_valid  (AF_ARB_valid),
      .AF_ARB_packet (AF_ARB_packet),
      .AF_ARB_ready  (AF_ARB_ready),
      .CTL_ARB_valid (CTL_ARB_valid),
      .CTL_ARB_packet(CTL_ARB_packet),
      .CTL_ARB_ready (CTL_ARB_ready),
      .ARB_NI_valid  (ARB_NI_valid),
      .ARB_NI_packet (ARB_NI_packet),
      .ARB_NI_ready  (ARB_NI_ready),
      .ARB_pktCount  (ARB_pktCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the output stage is a queue holding at most one packet.
   // last_w records who won the previous grant (0 = AF, 1 = CTL).
   // exp_cnt is the saturating delivery count.
   logic [PW-1:0] slot_q[$];
   int            last_w;
   int            exp_cnt;

   // DUT observations captured inside cycle(), used by the directed checks.
   logic          obs_af, obs_ctl, obs_vld;
   logic [PW-1:0] obs_pkt;
   int            obs_grant;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [PW-1:0] rpkt();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[PW-1:0];
   endfunction

   task automatic model_reset();
      slot_q.delete();
      last_w  = 1;
      exp_cnt = 0;
   endtask

   // One clock cycle. Call it just after a falling edge, with the inputs
   // already driven. It checks the DUT against the model, advances both
   // across the rising edge, and returns at the next falling edge.
   task automatic cycle(input string tag);
      int winner;
      bit can_load;
      #1;
      obs_af    = AF_ARB_ready;
      obs_ctl   = CTL_ARB_ready;
      obs_vld   = ARB_NI_valid;
      obs_pkt   = ARB_NI_packet;
      obs_grant = obs_ctl ? 1 : (obs_af ? 0 : 2);

      can_load = (slot_q.size() == 0) || ARB_NI_ready;
      winner   = -1;
      if (can_load) begin
         if (AF_ARB_valid && CTL_ARB_valid) winner = (last_w == 0) ? 1 : 0;
         else if (AF_ARB_valid)             winner = 0;
         else if (CTL_ARB_valid)            winner = 1;
      end

      chk({tag, "_af_rdy"},  AF_ARB_ready,  winner == 0);
      chk({tag, "_ctl_rdy"}, CTL_ARB_ready, winner == 1);
      chk({tag, "_ni_vld"},  ARB_NI_valid,  slot_q.size() != 0);
      if (slot_q.size() != 0)
         chk({tag, "_ni_pkt"}, ARB_NI_packet, slot_q[0]);
      chk({tag, "_cnt"}, ARB_pktCount, exp_cnt);

      @(posedge clk);
      if (slot_q.size() != 0 && ARB_NI_ready) begin
         void'(slot_q.pop_front());
         if (exp_cnt < 65535) exp_cnt++;
      end
      if (winner == 0) begin
         slot_q.push_back(AF_ARB_packet);
         last_w = 0;
      end else if (winner == 1) begin
         slot_q.push_back(CTL_ARB_packet);
         last_w = 1;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [PW-1:0] p;
      int c0;

      // Reset asserted from time 0, with both sources requesting.
      rst            = 1'b0;
      AF_ARB_valid   = 1'b1;
      CTL_ARB_valid  = 1'b1;
      AF_ARB_packet  = rpkt();
      CTL_ARB_packet = rpkt();
      ARB_NI_ready   = 1'b0;
      model_reset();
      #1;
      chk("rst_ni_vld",  ARB_NI_valid,  1'b0);
      chk("rst_ni_pkt",  ARB_NI_packet, '0);
      chk("rst_cnt",     ARB_pktCount,  16'd0);
      chk("rst_af_rdy",  AF_ARB_ready,  1'b0);
      chk("rst_ctl_rdy", CTL_ARB_ready, 1'b0);
      @(negedge clk);
      rst           = 1'b1;
      CTL_ARB_valid = 1'b0;

      // AF-only request with a known packet.
      AF_ARB_valid  = 1'b1;
      AF_ARB_packet = 56'h00_0102_A5A5A5A5;
      ARB_NI_ready  = 1'b1;
      cycle("af0");
      chk("af0_accept", obs_af, 1'b1);
      AF_ARB_valid = 1'b0;
      #1;
      chk("af1_vld", ARB_NI_valid, 1'b1);
      chk("af1_pkt", ARB_NI_packet, 56'h00_0102_A5A5A5A5);
      cycle("af1");
      #1;
      chk("af2_cnt", ARB_pktCount, 16'd1);
      chk("af2_vld", ARB_NI_valid, 1'b0);

      // Run the count up to 7 and leave the stage full.
      AF_ARB_valid = 1'b1;
      ARB_NI_ready = 1'b1;
      repeat (7) begin
         AF_ARB_packet = rpkt();
         cycle("fill");
      end
      AF_ARB_valid = 1'b0;
      ARB_NI_ready = 1'b0;
      cycle("fill_hold");
      #1;
      chk("pre_rst_cnt", ARB_pktCount, 16'd7);
      chk("pre_rst_vld", ARB_NI_valid, 1'b1);

      // Pulse reset low in mid-cycle while the stage is full.
      AF_ARB_valid  = 1'b1;
      CTL_ARB_valid = 1'b1;
      ARB_NI_ready  = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_vld",     ARB_NI_valid,  1'b0);
      chk("mid_rst_cnt",     ARB_pktCount,  16'd0);
      chk("mid_rst_pkt",     ARB_NI_packet, '0);
      chk("mid_rst_af_rdy",  AF_ARB_ready,  1'b0);
      chk("mid_rst_ctl_rdy", CTL_ARB_ready, 1'b0);
      AF_ARB_valid  = 1'b0;
      CTL_ARB_valid = 1'b0;
      rst           = 1'b1;
      model_reset();
      @(negedge clk);

      // Tie for six cycles: AF goes first, then strict alternation with no bubbles.
      AF_ARB_valid  = 1'b1;
      CTL_ARB_valid = 1'b1;
      ARB_NI_ready  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         AF_ARB_packet  = rpkt();
         CTL_ARB_packet = rpkt();
         cycle("tie");
         chk("tie_grant", obs_grant, i % 2);
         if (i > 0) chk("tie_no_bubble", obs_vld, 1'b1);
      end
      AF_ARB_valid  = 1'b0;
      CTL_ARB_valid = 1'b0;
      cycle("tie_drain");
      chk("tie_last_vld", obs_vld, 1'b1);
      cycle("tie_idle");

      // Stall: the stage is full and the NI holds off for five cycles.
      AF_ARB_valid  = 1'b1;
      AF_ARB_packet = rpkt();
      p             = AF_ARB_packet;
      ARB_NI_ready  = 1'b0;
      cycle("stall_load");
      CTL_ARB_valid = 1'b1;
      c0 = exp_cnt;
      for (int i = 0; i < 5; i++) begin
         AF_ARB_packet  = rpkt();
         CTL_ARB_packet = rpkt();
         cycle("stall");
         chk("stall_rdy", {obs_af, obs_ctl}, 2'b00);
         chk("stall_pkt", obs_pkt, p);
      end
      AF_ARB_valid  = 1'b0;
      CTL_ARB_valid = 1'b0;
      ARB_NI_ready  = 1'b1;
      cycle("stall_rel");
      #1;
      chk("stall_cnt", ARB_pktCount, c0 + 1);
      chk("stall_vld", ARB_NI_valid, 1'b0);

      // Delivery and CTL load on the same edge.
      AF_ARB_valid  = 1'b1;
      AF_ARB_packet = rpkt();
      ARB_NI_ready  = 1'b0;
      cycle("ovl_load");
      AF_ARB_valid   = 1'b0;
      CTL_ARB_valid  = 1'b1;
      CTL_ARB_packet = rpkt();
      p              = CTL_ARB_packet;
      ARB_NI_ready   = 1'b1;
      cycle("ovl");
      chk("ovl_ctl_rdy", obs_ctl, 1'b1);
      CTL_ARB_valid = 1'b0;
      ARB_NI_ready  = 1'b0;
      #1;
      chk("ovl_pkt", ARB_NI_packet, p);
      chk("ovl_vld", ARB_NI_valid, 1'b1);
      cycle("ovl_hold");

      // Random traffic compared cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         AF_ARB_valid   = 1'($urandom_range(0, 1));
         CTL_ARB_valid  = 1'($urandom_range(0, 1));
         ARB_NI_ready   = ($urandom_range(0, 3) != 0);
         AF_ARB_packet  = rpkt();
         CTL_ARB_packet = rpkt();
         cycle("rnd");
      end

      // Saturation: enough back-to-back deliveries to pass 16'hFFFF.
      CTL_ARB_valid = 1'b0;
      AF_ARB_valid  = 1'b1;
      ARB_NI_ready  = 1'b1;
      for (int i = 0; i < 65545; i++) begin
         AF_ARB_packet = rpkt();
         cycle("sat");
      end
      #1;
      chk("sat_cnt", ARB_pktCount, 16'hFFFF);
      cycle("sat_more");
      #1;
      chk("sat_hold", ARB_pktCount, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
